lut_conf_stream_tx: RTL
=======================

// Module: lut_conf_stream_tx
// PURPOSE
//  Transmit side of the LUT configuration stream consumed by lut_conf_fsm_stream.
//  Pulls packed 32-bit entries {base[31:16], slope[15:0]} from an upstream source (DMA/ROM) via valid/ready.
//  Generates the conf_mode rising edge and settle gap, then serialises LUT_DEPTH entries as base/slope beats.
//  Sits between the host/config memory and lut_conf_fsm_stream; replaces the bench-driven loader in silicon.
// PARAMETERS
//  DATA_WIDTH  16   width of one stream beat (base or slope)
//  SEG_BITS    8    entry counter width; LUT_DEPTH <= 2**SEG_BITS
//  LUT_DEPTH   256  number of {base,slope} entries per configuration
// PORTS
//  clk            in   1             clock
//  rst            in   1             synchronous, active-high reset
//  start          in   1             pulse: begin a configuration (ignored unless IDLE)
//  abort          in   1             cancel in-progress configuration
//  src_valid      in   1             upstream entry valid
//  src_data       in   2*DATA_WIDTH  packed entry {base, slope}
//  src_ready      out  1             entry accepted when src_valid & src_ready at posedge
//  conf_mode      out  1             config-mode level to receiver
//  din_valid      out  1             one-cycle beat strobe
//  din            out  DATA_WIDTH    beat payload (signed), 0 when din_valid=0
//  busy           out  1             high from ARM through DONE
//  done           out  1             one-cycle pulse after last slope beat
//  entry_cnt_dbg  out  SEG_BITS      entries fully sent in current run
//  state_dbg      out  3             encoded current state
// BEHAVIOUR
//  Reset: state=IDLE; conf_mode, din_valid, din, busy, done, entry_cnt_dbg, slope_q all 0.
//  All outputs registered except src_ready = (state==BASE) (combinational from state).
//  States/transitions (evaluated each posedge; abort has priority over all but rst):
//   IDLE   : start -> ARM, cnt<=0.
//   ARM    : conf_mode<=0 (guarantees a low cycle) -> RISE.
//   RISE   : conf_mode<=1 (rising edge) -> SETTLE.
//   SETTLE : conf_mode held 1, no beat (receiver settles into GET_B) -> BASE.
//   BASE   : on src handshake: din<=src_data[31:16], din_valid<=1, slope_q<=src_data[15:0] -> SLOPE;
//            otherwise din_valid<=0, din<=0, stay.
//   SLOPE  : din<=slope_q, din_valid<=1; if cnt==LUT_DEPTH-1 -> DONE else cnt++ -> BASE.
//   DONE   : din_valid<=0, din<=0, cnt<=LUT_DEPTH (saturated display), done<=1, conf_mode<=0, busy<=0 -> IDLE.
//  Beats: base and slope of one entry are always on adjacent cycles; with src_valid held high
//   stream is gap-free B,S,B,S (2 cycles/entry). Stalls only occur between entries.
//  Latency: start sampled at edge e0; conf_mode=0 after e1, =1 after e2; src_ready after e3;
//   first base beat after e4; done visible after e(4+2*LUT_DEPTH).
//  start while busy ignored. start and abort same cycle in IDLE: abort wins (stay IDLE).
//  abort (any non-IDLE state): next cycle conf_mode=0, din_valid=0, din=0, busy=0, no done, -> IDLE;
//   a partially sent entry is dropped (slope beat not emitted).
//  rst mid-stream: identical to power-on reset; no done pulse.
//  entry_cnt_dbg width SEG_BITS; when LUT_DEPTH==2**SEG_BITS the DONE value wraps to 0 (debug only).
//  src_data sampled only on handshake; contents ignored otherwise.
// STRUCTURE
//  Shared package lut_cfg_pkg: DATA_WIDTH/SEG_BITS/LUT_DEPTH defaults, typedef lut_entry_t
//   (packed struct {logic signed [15:0] base; logic signed [15:0] slope;}), tx state enum
//   (IDLE=0,ARM,RISE,SETTLE,BASE,SLOPE,DONE) shared with state_dbg decode in benches.
//  Single flat module; no sub-module (FSM + counter + slope holding register).
// TESTING
//  1 Reset: hold rst 3 cycles -> all outputs 0, src_ready=0, state_dbg=0.
//  2 Loopback into lut_conf_fsm_stream + lut_core, src_valid=1, entry i={i, 16'h0100+i}: conf_mode low
//    after e1, high after e2, first din=16'h0000 after e4, 512 contiguous beats, done after e516,
//    receiver configured=1, lookups 16'h0000/16'h01AB/16'hFFFF match golden base+slope*frac>>>8.
//  3 Random src_valid gaps (~50%): every base beat immediately followed by its slope beat; 256 entries,
//    receiver contents identical to test 2.
//  4 start pulsed at entries 10 and 200 while busy -> ignored, single done pulse only.
//  5 abort at entry 100 in SLOPE -> next cycle conf_mode=0, din_valid=0, no done; re-start completes
//    a full run and receiver reaches configured=1.
//  6 rst asserted at entry 50, then LUT_DEPTH=4 build: start -> exactly 8 beats, done after e12.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared LUT configuration stream definitions: default sizing, entry layout,
// and the transmitter state encoding that benches use to decode state_dbg.
package lut_cfg_pkg;

  localparam int unsigned LUT_DATA_WIDTH = 16;
  localparam int unsigned LUT_SEG_BITS   = 8;
  localparam int unsigned LUT_DEPTH_DEF  = 256;

  typedef struct packed {
    logic signed [15:0] base;
    logic signed [15:0] slope;
  } lut_entry_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_ARM    = 3'd1,
    TX_RISE   = 3'd2,
    TX_SETTLE = 3'd3,
    TX_BASE   = 3'd4,
    TX_SLOPE  = 3'd5,
    TX_DONE   = 3'd6
  } tx_state_t;

endpackage

// File: rtl/lut_conf_stream_tx.sv
// LUT configuration stream transmitter: raises conf_mode, waits a settle cycle,
// then serialises LUT_DEPTH {base,slope} entries pulled from an upstream source.
module lut_conf_stream_tx
  import lut_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LUT_DATA_WIDTH,
  parameter int unsigned SEG_BITS   = LUT_SEG_BITS,
  parameter int unsigned LUT_DEPTH  = LUT_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         src_valid,
  input  logic [2*DATA_WIDTH-1:0]      src_data,
  output logic                         src_ready,
  output logic                         conf_mode,
  output logic                         din_valid,
  output logic signed [DATA_WIDTH-1:0] din,
  output logic                         busy,
  output logic                         done,
  output logic [SEG_BITS-1:0]          entry_cnt_dbg,
  output logic [2:0]                   state_dbg
);

  localparam logic [SEG_BITS-1:0] LAST_ENTRY = SEG_BITS'(LUT_DEPTH - 1);
  localparam logic [SEG_BITS-1:0] CNT_DONE   = SEG_BITS'(LUT_DEPTH);

  tx_state_t             state;
  logic [SEG_BITS-1:0]   cnt;
  logic [DATA_WIDTH-1:0] slope_q;

  // Upstream may only hand over an entry when a base beat can go out next cycle,
  // which keeps base and slope of one entry on adjacent cycles.
  assign src_ready     = (state == TX_BASE);
  assign entry_cnt_dbg = cnt;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      cnt       <= '0;
      slope_q   <= '0;
      conf_mode <= 1'b0;
      din_valid <= 1'b0;
      din       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort drops any half-sent entry; in IDLE it also masks a same-cycle start.
        if (state != TX_IDLE) begin
          state     <= TX_IDLE;
          conf_mode <= 1'b0;
          din_valid <= 1'b0;
          din       <= '0;
          busy      <= 1'b0;
        end
      end else begin
        case (state)
          TX_IDLE: begin
            if (start) begin
              state <= TX_ARM;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          TX_ARM: begin
            conf_mode <= 1'b0;
            state     <= TX_RISE;
          end
          TX_RISE: begin
            conf_mode <= 1'b1;
            state     <= TX_SETTLE;
          end
          TX_SETTLE: begin
            state <= TX_BASE;
          end
          TX_BASE: begin
            if (src_valid) begin
              din       <= src_data[2*DATA_WIDTH-1:DATA_WIDTH];
              din_valid <= 1'b1;
              slope_q   <= src_data[DATA_WIDTH-1:0];
              state     <= TX_SLOPE;
            end else begin
              din_valid <= 1'b0;
              din       <= '0;
            end
          end
          TX_SLOPE: begin
            din       <= slope_q;
            din_valid <= 1'b1;
            if (cnt == LAST_ENTRY) begin
              state <= TX_DONE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= TX_BASE;
            end
          end
          TX_DONE: begin
            din_valid <= 1'b0;
            din       <= '0;
            cnt       <= CNT_DONE;
            done      <= 1'b1;
            conf_mode <= 1'b0;
            busy      <= 1'b0;
            state     <= TX_IDLE;
          end
          default: begin
            state <= TX_IDLE;
          end
        endcase
      end
    end
  end

endmodule
